axil_regfile_gen: RTL and testbench



---
 rtl/axil_regfile_gen.sv | 172 +++++++++++++++++
 tb/tb_axil_regfile_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_gen.sv
// AXI4-Lite register file with per-register access modes (RW/RO/W1C/SC), PL write ports and masked irq.
// Optional: define AXIL_REGFILE_LOCK_EN to add a lock input that blocks PS writes to RW/SC registers.
module axil_regfile_gen #(
    parameter int                      ADDR_WIDTH      = 8,
    parameter int                      NUM_REGS        = 16,
    parameter logic [2*NUM_REGS-1:0]   REG_MODE        = {NUM_REGS{2'b00}},
    parameter logic [32*NUM_REGS-1:0]  REG_RESET       = {NUM_REGS*32{1'b0}},
    parameter int                      IRQ_STS_IDX     = 0,
    parameter int                      IRQ_MSK_IDX     = 1,
    parameter bit                      PIPELINE_OUTPUT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef AXIL_REGFILE_LOCK_EN
    input  logic                       lock,
`endif
    input  logic [NUM_REGS-1:0]        pl_wr_en,
    input  logic [32*NUM_REGS-1:0]     pl_wr_data,
    output logic [32*NUM_REGS-1:0]     reg_q,
    output logic [NUM_REGS-1:0]        ps_wr_pulse,
    output logic                       irq,
    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready
);
    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;
    localparam logic [1:0] MODE_SC  = 2'd3;
    localparam int         IDX_W    = ADDR_WIDTH - 2;

    logic [NUM_REGS-1:0][31:0] regs, regs_nxt;
    logic [IDX_W-1:0]          aw_idx, ar_idx;
    logic                      wr_start, wr_hs, rd_start, rd_hs, rd_pop;
    logic                      aw_hit, ar_hit, ps_locked;
    logic [1:0]                aw_mode, wr_resp;
    logic [NUM_REGS-1:0]       wr_commit;
    logic [31:0]               strb_mask, rd_data, ps_mask, pl_val;
    logic                      rd_valid, pipe_valid;
    logic [31:0]               rd_q, pipe_data;
    logic [1:0]                rd_resp_q, pipe_resp;
    logic                      unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign aw_idx    = s_axil_awaddr[ADDR_WIDTH-1:2];
    assign ar_idx    = s_axil_araddr[ADDR_WIDTH-1:2];
    assign wr_hs     = s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready;
    assign rd_hs     = s_axil_arvalid && s_axil_arready;
    assign wr_start  = s_axil_awvalid && s_axil_wvalid && !s_axil_awready && !s_axil_wready
                       && (!s_axil_bvalid || s_axil_bready);
    assign rd_start  = s_axil_arvalid && !s_axil_arready
                       && (!rd_valid || s_axil_rready || (PIPELINE_OUTPUT && !pipe_valid));
    assign rd_pop    = PIPELINE_OUTPUT ? (!pipe_valid || s_axil_rready) : s_axil_rready;
    assign strb_mask = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                        {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};

`ifdef AXIL_REGFILE_LOCK_EN
    assign ps_locked = lock && (aw_mode == MODE_RW || aw_mode == MODE_SC);
`else
    assign ps_locked = 1'b0;
`endif

    always_comb begin
        aw_hit  = 1'b0;
        aw_mode = MODE_RW;
        ar_hit  = 1'b0;
        rd_data = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (aw_idx == IDX_W'(k)) begin
                aw_hit  = 1'b1;
                aw_mode = REG_MODE[2*k +: 2];
            end
            if (ar_idx == IDX_W'(k)) begin
                ar_hit  = 1'b1;
                rd_data = regs[k];
            end
        end
        if (!aw_hit)
            wr_resp = 2'b11;
        else if (aw_mode == MODE_RO || ps_locked)
            wr_resp = 2'b10;
        else
            wr_resp = 2'b00;
    end

    // PS wins on strobed lanes; for W1C a PL set beats a simultaneous PS clear.
    always_comb begin
        regs_nxt  = regs;
        wr_commit = '0;
        ps_mask   = 32'h0;
        pl_val    = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_commit[k] = wr_hs && (wr_resp == 2'b00) && (aw_idx == IDX_W'(k));
            ps_mask      = wr_commit[k] ? strb_mask : 32'h0;
            pl_val       = pl_wr_en[k] ? pl_wr_data[32*k +: 32] : 32'h0;
            case (REG_MODE[2*k +: 2])
                MODE_W1C: regs_nxt[k] = (regs[k] & ~(ps_mask & s_axil_wdata)) | pl_val;
                MODE_RO:  regs_nxt[k] = pl_wr_en[k] ? pl_val : regs[k];
                MODE_SC:  regs_nxt[k] = (pl_val & ~ps_mask) | (s_axil_wdata & ps_mask);
                default:  regs_nxt[k] = ((pl_wr_en[k] ? pl_val : regs[k]) & ~ps_mask)
                                        | (s_axil_wdata & ps_mask);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs           <= REG_RESET;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= 2'b00;
            s_axil_arready <= 1'b0;
            ps_wr_pulse    <= '0;
            irq            <= 1'b0;
            rd_valid       <= 1'b0;
            rd_q           <= 32'h0;
            rd_resp_q      <= 2'b00;
            pipe_valid     <= 1'b0;
            pipe_data      <= 32'h0;
            pipe_resp      <= 2'b00;
        end else begin
            regs           <= regs_nxt;
            s_axil_awready <= wr_start;
            s_axil_wready  <= wr_start;
            s_axil_arready <= rd_start;
            ps_wr_pulse    <= wr_commit;
            irq            <= |(regs[IRQ_STS_IDX] & regs[IRQ_MSK_IDX]);
            if (wr_hs) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_resp;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            if (rd_hs) begin
                rd_valid  <= 1'b1;
                rd_q      <= ar_hit ? rd_data : 32'h0;
                rd_resp_q <= ar_hit ? 2'b00 : 2'b11;
            end else if (rd_pop) begin
                rd_valid  <= 1'b0;
            end
            if (PIPELINE_OUTPUT && (!pipe_valid || s_axil_rready)) begin
                pipe_valid <= rd_valid;
                pipe_data  <= rd_q;
                pipe_resp  <= rd_resp_q;
            end
        end
    end

    assign reg_q         = regs;
    assign s_axil_rvalid = PIPELINE_OUTPUT ? pipe_valid : rd_valid;
    assign s_axil_rdata  = PIPELINE_OUTPUT ? pipe_data  : rd_q;
    assign s_axil_rresp  = PIPELINE_OUTPUT ? pipe_resp  : rd_resp_q;

endmodule

// File: tb/tb_axil_regfile_gen.sv
// Scoreboard bench for axil_regfile_gen: directed cases plus randomized AXI/PL traffic against a reference model.
`timescale 1ns/1ps
module tb_axil_regfile_gen;
    localparam int AW   = 6;
    localparam int NUM  = 8;
    localparam bit PIPE = 1'b1;
    // r0 W1C status, r1 RW mask, r2 RW, r3 RO, r4 SC, r5 RW, r6 W1C, r7 RW
    localparam logic [2*NUM-1:0]  MODES  = {2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2};
    localparam logic [32*NUM-1:0] RESETS = {32'h0, 32'h0, 32'h12345678, 32'h0,
                                            32'h0BADF00D, 32'hA5A50000, 32'h0, 32'h0};

    logic              clk, rst_n;
`ifdef AXIL_REGFILE_LOCK_EN
    logic              lock;
`endif
    logic [NUM-1:0]    pl_wr_en;
    logic [32*NUM-1:0] pl_wr_data, reg_q;
    logic [NUM-1:0]    ps_wr_pulse;
    logic              irq;
    logic [AW-1:0]     s_axil_awaddr, s_axil_araddr;
    logic [2:0]        s_axil_awprot, s_axil_arprot;
    logic              s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [31:0]       s_axil_wdata, s_axil_rdata;
    logic [3:0]        s_axil_wstrb;
    logic [1:0]        s_axil_bresp, s_axil_rresp;
    logic              s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic              s_axil_rvalid, s_axil_rready;

    axil_regfile_gen #(
        .ADDR_WIDTH(AW), .NUM_REGS(NUM), .REG_MODE(MODES), .REG_RESET(RESETS),
        .IRQ_STS_IDX(0), .IRQ_MSK_IDX(1), .PIPELINE_OUTPUT(PIPE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AXIL_REGFILE_LOCK_EN
        .lock(lock),
`endif
        .pl_wr_en(pl_wr_en), .pl_wr_data(pl_wr_data), .reg_q(reg_q),
        .ps_wr_pulse(ps_wr_pulse), .irq(irq),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] mode_of(input int k);
        return MODES[2*k +: 2];
    endfunction

    // Reference model: register contents as plain words, updated once per clock from observed handshakes.
    logic [31:0]   m  [NUM];
    logic [31:0]   nx [NUM];
    logic [NUM-1:0] m_pulse;
    logic          m_irq;
    bit            m_ok = 1'b0;
    int            aw_cnt = 0, ar_cnt = 0;
    logic [1:0]    bq [$];
    logic [33:0]   rq [$];
    int            widx, ridx;
    logic [1:0]    wresp, md;
    logic [31:0]   setv;
    logic [1:0]    last_bresp, last_rresp;
    logic [31:0]   last_rdata;
    logic [32*NUM-1:0] flat;
    bit            rand_rdy = 1'b0, rand_pl = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) m[k] = RESETS[32*k +: 32];
            m_pulse = '0;
            m_irq   = 1'b0;
            m_ok    = 1'b1;
            bq.delete();
            rq.delete();
        end else begin
            m_irq   = |(m[0] & m[1]);
            m_pulse = '0;
            if (s_axil_arvalid && s_axil_arready) begin
                chk("rd_outstanding", (rq.size() <= (PIPE ? 1 : 0)), 1);
                ar_cnt++;
                ridx = int'(s_axil_araddr[AW-1:2]);
                if (ridx >= NUM) rq.push_back({2'b11, 32'h0});
                else             rq.push_back({2'b00, m[ridx]});
            end
            for (int k = 0; k < NUM; k++) begin
                setv  = pl_wr_en[k] ? pl_wr_data[32*k +: 32] : 32'h0;
                nx[k] = m[k];
                case (mode_of(k))
                    2'd2:    nx[k] = m[k] | setv;
                    2'd3:    nx[k] = setv;
                    default: if (pl_wr_en[k]) nx[k] = setv;
                endcase
            end
            if (s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready) begin
                chk("wr_outstanding", bq.size(), 0);
                aw_cnt++;
                widx = int'(s_axil_awaddr[AW-1:2]);
                md   = 2'd0;
                if (widx >= NUM) wresp = 2'b11;
                else begin
                    md    = mode_of(widx);
                    wresp = (md == 2'd1) ? 2'b10 : 2'b00;
`ifdef AXIL_REGFILE_LOCK_EN
                    if (lock && (md == 2'd0 || md == 2'd3)) wresp = 2'b10;
`endif
                end
                bq.push_back(wresp);
                if (wresp == 2'b00) begin
                    m_pulse[widx] = 1'b1;
                    setv = pl_wr_en[widx] ? pl_wr_data[32*widx +: 32] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (s_axil_wstrb[b]) begin
                            if (md == 2'd2)
                                nx[widx][8*b +: 8] = (m[widx][8*b +: 8] & ~s_axil_wdata[8*b +: 8])
                                                     | setv[8*b +: 8];
                            else
                                nx[widx][8*b +: 8] = s_axil_wdata[8*b +: 8];
                        end
                    end
                end
            end
            for (int k = 0; k < NUM; k++) m[k] = nx[k];
        end
    end

    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            for (int k = 0; k < NUM; k++) flat[32*k +: 32] = m[k];
            chk("reg_q", reg_q, flat);
            chk("irq", irq, m_irq);
            chk("ps_wr_pulse", ps_wr_pulse, m_pulse);
            if (s_axil_bvalid && s_axil_bready) begin
                chk("b_expected", (bq.size() != 0), 1);
                if (bq.size() != 0) chk("bresp", s_axil_bresp, bq.pop_front());
                last_bresp = s_axil_bresp;
            end
            if (s_axil_rvalid && s_axil_rready) begin
                chk("r_expected", (rq.size() != 0), 1);
                if (rq.size() != 0) chk("rresp_rdata", {s_axil_rresp, s_axil_rdata}, rq.pop_front());
                last_rresp = s_axil_rresp;
                last_rdata = s_axil_rdata;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            s_axil_bready = ($urandom % 4) != 0;
            s_axil_rready = ($urandom % 4) != 0;
        end
        if (rand_pl) begin
            for (int k = 0; k < NUM; k++) begin
                pl_wr_en[k] = ($urandom % 8) == 0;
                pl_wr_data[32*k +: 32] = $urandom;
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(posedge clk);
        #1;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axil_awready && n < 300);
        chk("aw_accept", s_axil_awready, 1);
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a);
        int n = 0;
        @(posedge clk);
        #1;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axil_arready && n < 300);
        chk("ar_accept", s_axil_arready, 1);
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", bq.size() + rq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, base_aw, base_ar;
        rst_n = 1'b0;
`ifdef AXIL_REGFILE_LOCK_EN
        lock = 1'b0;
`endif
        pl_wr_en = '0; pl_wr_data = '0;
        s_axil_awaddr = '0; s_axil_awprot = 3'b0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
        s_axil_araddr = '0; s_axil_arprot = 3'b0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reg2", reg_q[95:64], 32'hA5A50000);
        chk("rst_irq", irq, 0);
        chk("rst_bvalid", s_axil_bvalid, 0);
        chk("rst_rvalid", s_axil_rvalid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        axi_write(6'h08, 32'hFFFFFFFF, 4'hF);
        axi_write(6'h08, 32'h11223344, 4'h3);
        wait_idle();
        chk("rw_strobe_reg2", reg_q[95:64], 32'hFFFF3344);
        axi_read(6'h0A);
        wait_idle();
        chk("rw_readback", last_rdata, 32'hFFFF3344);

        axi_write(6'h0C, 32'h0, 4'hF);
        wait_idle();
        chk("ro_bresp", last_bresp, 2'b10);
        chk("ro_unchanged", reg_q[127:96], 32'h0BADF00D);
        axi_read(6'(4 * NUM));
        wait_idle();
        chk("decerr_rresp", last_rresp, 2'b11);
        chk("decerr_rdata", last_rdata, 32'h0);

        axi_write(6'h04, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        pl_wr_data[31:0] = 32'h5; pl_wr_en = 8'h01;
        @(posedge clk);
        #1;
        pl_wr_data[31:0] = 32'h1;
        axi_write(6'h00, 32'h5, 4'hF);
        pl_wr_en = '0;
        wait_idle();
        chk("w1c_collision", reg_q[31:0], 32'h1);
        chk("irq_set", irq, 1);
        axi_write(6'h00, 32'h1, 4'hF);
        wait_idle();
        chk("w1c_clear", reg_q[31:0], 32'h0);
        chk("irq_clear", irq, 0);

        axi_read(6'h04);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axil_rvalid && n < 10);
        chk("rd_latency", n, PIPE ? 2 : 1);
        wait_idle();

        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        base_aw = aw_cnt; base_ar = ar_cnt;
        fork
            begin
                axi_write(6'h14, 32'hCAFE0001, 4'hF);
                axi_write(6'h1C, 32'hCAFE0002, 4'hF);
            end
            begin
                axi_read(6'h14);
                axi_read(6'h08);
                axi_read(6'h1C);
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_aw_count", aw_cnt - base_aw, 1);
                chk("bp_ar_count", ar_cnt - base_ar, PIPE ? 2 : 1);
                @(posedge clk);
                #1;
                s_axil_bready = 1'b1; s_axil_rready = 1'b1;
            end
        join
        wait_idle();

`ifdef AXIL_REGFILE_LOCK_EN
        lock = 1'b1;
        axi_write(6'h10, 32'h1, 4'hF);
        wait_idle();
        chk("lock_bresp", last_bresp, 2'b10);
        lock = 1'b0;
        axi_write(6'h10, 32'h1, 4'hF);
        wait_idle();
        chk("unlock_bresp", last_bresp, 2'b00);
`endif

        rand_rdy = 1'b1; rand_pl = 1'b1;
        fork
            for (int i = 0; i < 60; i++)
                axi_write(AW'($urandom_range(0, 4*NUM+11)), $urandom, 4'($urandom_range(0, 15)));
            for (int i = 0; i < 60; i++)
                axi_read(AW'($urandom_range(0, 4*NUM+11)));
        join
        rand_rdy = 1'b0; rand_pl = 1'b0;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1; pl_wr_en = '0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
